// File: rtl/pipeline_ctrl_if.sv
// Stall/flush bundle between the pipeline stages and the central pipeline controller.
interface pipeline_ctrl_if;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic [31:0] excepttype;
    logic [31:0] cp0_epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;

    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excepttype, cp0_epc,
        input  stall, flush, new_pc, stall_timeout
    );

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excepttype, cp0_epc,
        output stall, flush, new_pc, stall_timeout
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the 6-stage pipeline with a stall watchdog.
// Optional performance counters are enabled with the PIPE_PERF_CNT_EN macro.
module pipeline_ctrl #(
    parameter logic [31:0] EXC_BASE      = 32'h0000_0000,
    parameter int          STALL_TIMEOUT = 1024,
    parameter int          CNT_W         = 11
) (
    input  logic        clk,
    input  logic        rst,
    pipeline_ctrl_if.slave ctrl
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_flush_cnt
`endif
);
    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    localparam logic [CNT_W-1:0] WDOG_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] WDOG_TRIP = CNT_W'(STALL_TIMEOUT - 1);

    state_t           state_q;
    logic [CNT_W-1:0] wdog_q;
    logic             timeout_q;
    logic             exc_acc;
    logic [5:0]       stall_d;
    logic [31:0]      new_pc_d;

    // FLUSH blocks a second pulse for a held exception code.
    assign exc_acc = !rst && (ctrl.excepttype != 32'h0) && (state_q != FLUSH);

    always_comb begin
        stall_d = 6'b000000;
        if (!rst && !exc_acc && state_q != FLUSH) begin
            if (ctrl.stallreq_mem)
                stall_d = 6'b011111;
            else if (ctrl.stallreq_ex)
                stall_d = 6'b001111;
            else if (ctrl.stallreq_id || ctrl.stallreq_if)
                stall_d = 6'b000111;
        end
    end

    always_comb begin
        new_pc_d = 32'h0;
        if (exc_acc) begin
            case (ctrl.excepttype)
                32'h1:   new_pc_d = EXC_BASE + 32'h20;
                32'he:   new_pc_d = ctrl.cp0_epc;
                default: new_pc_d = EXC_BASE + 32'h40;
            endcase
        end
    end

    assign ctrl.stall         = stall_d;
    assign ctrl.flush         = exc_acc;
    assign ctrl.new_pc        = new_pc_d;
    assign ctrl.stall_timeout = timeout_q;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= 32'h0;
            perf_flush_q <= 32'h0;
        end else begin
            if (stall_d != 6'b0) perf_stall_q <= perf_stall_q + 32'h1;
            if (exc_acc)         perf_flush_q <= perf_flush_q + 32'h1;
        end
    end

    assign perf_stall_cyc = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (exc_acc)
                state_q <= FLUSH;
            else if (stall_d != 6'b0)
                state_q <= STALL;
            else
                state_q <= RUN;

            if (stall_d == 6'b0 || exc_acc)
                wdog_q <= '0;
            else if (wdog_q != WDOG_MAX)
                wdog_q <= wdog_q + 1'b1;

            // Trip on the cycle the count reaches the limit while still stalled.
            if (stall_d != 6'b0 && wdog_q >= WDOG_TRIP)
                timeout_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (EXC_BASE=0, STALL_TIMEOUT=4).
module tb_pipeline_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_ctrl_if bus ();

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_stall_cyc;
    logic [31:0] perf_flush_cnt;
`endif

    pipeline_ctrl #(
        .EXC_BASE(32'h0000_0000),
        .STALL_TIMEOUT(4),
        .CNT_W(11)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ctrl(bus)
`ifdef PIPE_PERF_CNT_EN
        ,
        .perf_stall_cyc(perf_stall_cyc),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic f, input logic d, input logic e, input logic m);
        bus.stallreq_if  = f;
        bus.stallreq_id  = d;
        bus.stallreq_ex  = e;
        bus.stallreq_mem = m;
    endtask

    task automatic outs(input string tag, input logic [5:0] st, input logic fl, input logic [31:0] pc);
        #1;
        chk({tag, ".stall"}, {26'h0, bus.stall}, {26'h0, st});
        chk({tag, ".flush"}, {31'h0, bus.flush}, {31'h0, fl});
        chk({tag, ".new_pc"}, bus.new_pc, pc);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req(0, 0, 0, 0);
        bus.excepttype = 32'h0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // reset holds everything quiet even with every request raised
        rst = 1'b1;
        req(1, 1, 1, 1);
        bus.excepttype = 32'h8;
        bus.cp0_epc = 32'h0;
        tick();
        tick();
        outs("rst", 6'b000000, 1'b0, 32'h0);
        chk("rst.timeout", {31'h0, bus.stall_timeout}, 32'h0);

        // stall priority: ex, then mem on top
        rst = 1'b0;
        req(0, 0, 0, 0);
        bus.excepttype = 32'h0;
        tick();
        req(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            outs("ex", 6'b001111, 1'b0, 32'h0);
            tick();
        end
        req(0, 0, 1, 1);
        outs("mem", 6'b011111, 1'b0, 32'h0);
        tick();
        req(0, 0, 0, 0);
        outs("idle", 6'b000000, 1'b0, 32'h0);
        tick();
        req(1, 0, 0, 0);
        outs("if", 6'b000111, 1'b0, 32'h0);
        tick();
        req(1, 1, 0, 0);
        outs("id", 6'b000111, 1'b0, 32'h0);
        tick();

        // held exception: pulse, blocked, pulse again
        do_reset();
        req(0, 0, 0, 1);
        bus.excepttype = 32'hc;
        outs("exc1", 6'b000000, 1'b1, 32'h40);
        tick();
        outs("exc2", 6'b000000, 1'b0, 32'h0);
        tick();
        outs("exc3", 6'b000000, 1'b1, 32'h40);
        tick();
        req(0, 0, 0, 0);
        bus.excepttype = 32'h0;
        outs("exc4", 6'b000000, 1'b0, 32'h0);
        tick();

        // vector mapping
        bus.excepttype = 32'he;
        bus.cp0_epc = 32'h0000_1234;
        outs("eret", 6'b000000, 1'b1, 32'h0000_1234);
        tick();
        bus.excepttype = 32'h0;
        tick();
        bus.excepttype = 32'h1;
        outs("intr", 6'b000000, 1'b1, 32'h20);
        tick();
        bus.excepttype = 32'h0;
        tick();
        bus.excepttype = 32'h8;
        outs("syscall", 6'b000000, 1'b1, 32'h40);
        tick();
        bus.excepttype = 32'h0;
        tick();
        bus.excepttype = 32'h20;
        req(1, 0, 1, 0);
        outs("other", 6'b000000, 1'b1, 32'h40);
        tick();
        bus.excepttype = 32'h0;
        outs("flushst", 6'b000000, 1'b0, 32'h0);
        tick();
        outs("postflush", 6'b001111, 1'b0, 32'h0);
        tick();
        req(0, 0, 0, 0);
        tick();

        // watchdog trips on the 5th stalled cycle and stays set
        do_reset();
        req(0, 1, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            #1;
            chk($sformatf("wdog.c%0d", i), {31'h0, bus.stall_timeout}, (i >= 5) ? 32'h1 : 32'h0);
            tick();
        end
        req(0, 0, 0, 0);
        #1;
        chk("wdog.sticky", {31'h0, bus.stall_timeout}, 32'h1);
        tick();
        do_reset();
        #1;
        chk("wdog.rst", {31'h0, bus.stall_timeout}, 32'h0);

        // a flush restarts the watchdog count
        req(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick();
        bus.excepttype = 32'h1;
        tick();
        bus.excepttype = 32'h0;
        for (int i = 0; i < 4; i++) tick();
        #1;
        chk("wdog.flushclr", {31'h0, bus.stall_timeout}, 32'h0);
        tick();
        #1;
        chk("wdog.retrip", {31'h0, bus.stall_timeout}, 32'h1);
        req(0, 0, 0, 0);

`ifdef PIPE_PERF_CNT_EN
        do_reset();
        #1;
        chk("perf.rst_stall", perf_stall_cyc, 32'd0);
        chk("perf.rst_flush", perf_flush_cnt, 32'd0);
        req(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick();
        req(0, 0, 0, 0);
        bus.excepttype = 32'h1;
        tick();
        bus.excepttype = 32'h0;
        tick();
        bus.excepttype = 32'h1;
        tick();
        bus.excepttype = 32'h0;
        tick();
        chk("perf.stall", perf_stall_cyc, 32'd5);
        chk("perf.flush", perf_flush_cnt, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
